// File: rtl/bus_out_port.sv
// ---------------------------------------------------------------------------
// bus_out_port
//
// Reader end of the shared system bus. Whenever the control word raises
// ld_out, the current bus value is captured into a small FIFO. The FIFO
// drains to an external consumer through a valid/ready handshake. The last
// value the consumer accepted is held in a display register that drives the
// computer's `out`.
//
// Ports
//   clk       in   1      system clock, all state changes on posedge
//   res       in   1      synchronous active-high reset, dominates all inputs
//   bus       in   WIDTH  shared system bus
//   ld_out    in   1      capture strobe for the bus value this cycle
//   tx_data   out  WIDTH  head-of-FIFO data, meaningful only while tx_valid
//   tx_valid  out  1      FIFO non-empty
//   tx_ready  in   1      consumer takes the head when tx_valid && tx_ready
//   out       out  WIDTH  display register: last value accepted by consumer
//   full      out  1      FIFO holds DEPTH entries
//   empty     out  1      FIFO holds no entries
//   ovf       out  1      sticky overflow: a capture was dropped while full
//   clr_ovf   in   1      synchronous clear of ovf (a same-cycle overflow wins)
// ---------------------------------------------------------------------------
module bus_out_port #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] bus,
    input  logic             ld_out,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    input  logic             clr_ovf
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] out_q,    out_d;
    logic             ovf_q,    ovf_d;

    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             ovf_set_s;

    // Status flags and handshake qualifiers, all derived from registered count.
    always_comb begin
        empty_s   = (count_q == CNT_ZERO);
        full_s    = (count_q == CNT_FULL);
        pop_s     = !empty_s && tx_ready;
        // A full FIFO still accepts a capture when the head leaves this cycle.
        push_s    = ld_out && (!full_s || pop_s);
        ovf_set_s = ld_out && full_s && !pop_s;
    end

    // Next-state for pointers, occupancy, display register and overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        ovf_d    = ovf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            out_d    = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
            out_d    = out_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Setting takes priority over a simultaneous clear.
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            out_q    <= {WIDTH{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are don't-care after reset, so only writes are gated.
    always_ff @(posedge clk) begin
        if (!res && push_s) begin
            mem_q[wr_ptr_q] <= bus;
        end
    end

    // Output wiring; tx_data reads the registered array directly (no bypass).
    always_comb begin
        tx_data  = mem_q[rd_ptr_q];
        tx_valid = !empty_s;
        out      = out_q;
        full     = full_s;
        empty    = empty_s;
        ovf      = ovf_q;
    end

endmodule

// File: tb/tb_bus_out_port.sv
// ---------------------------------------------------------------------------
// tb_bus_out_port
//
// Directed testbench for bus_out_port. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point, well away from
// the next active edge. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_bus_out_port;

    logic       clk;
    logic       res;
    logic [7:0] bus;
    logic       ld_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] out;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       clr_ovf;

    int errors = 0;
    int checks = 0;

    bus_out_port #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .res      (res),
        .bus      (bus),
        .ld_out   (ld_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .out      (out),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .clr_ovf  (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            ld_out = 1'b1;
            bus    = base + 8'(i);
            tick();
        end
        ld_out = 1'b0;
    endtask

    initial begin
        res      = 1'b1;
        bus      = 8'hFF;
        ld_out   = 1'b1;
        tx_ready = 1'b0;
        clr_ovf  = 1'b0;

        // 1. Reset dominates a simultaneous capture.
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_empty", 32'(empty), 32'd1);
            check_eq("rst_out",   32'(out),   32'h00);
            check_eq("rst_ovf",   32'(ovf),   32'd0);
            check_eq("rst_valid", 32'(tx_valid), 32'd0);
            check_eq("rst_full",  32'(full),  32'd0);
        end
        res    = 1'b0;
        ld_out = 1'b0;

        // 2. Single capture, visible after the edge, then handed off.
        ld_out = 1'b1;
        bus    = 8'h3C;
        tick();
        ld_out = 1'b0;
        check_eq("one_valid", 32'(tx_valid), 32'd1);
        check_eq("one_data",  32'(tx_data),  32'h3C);
        check_eq("one_out_hold", 32'(out),   32'h00);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("one_out",   32'(out),   32'h3C);
        check_eq("one_empty", 32'(empty), 32'd1);
        // Ready on an empty FIFO must not disturb out.
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("empty_rdy_out", 32'(out), 32'h3C);

        // 3. Fill, overflow, drain in order.
        push_n(8'h01, 4);
        check_eq("fill_full", 32'(full),    32'd1);
        check_eq("fill_head", 32'(tx_data), 32'h01);
        ld_out = 1'b1;
        bus    = 8'h05;
        tick();
        ld_out = 1'b0;
        check_eq("ovf_set",  32'(ovf),     32'd1);
        check_eq("ovf_full", 32'(full),    32'd1);
        check_eq("ovf_head", 32'(tx_data), 32'h01);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("drain_out", 32'(out), 32'(i + 1));
        end
        tx_ready = 1'b0;
        check_eq("drain_empty", 32'(empty), 32'd1);
        check_eq("ovf_sticky",  32'(ovf),   32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf_clr", 32'(ovf), 32'd0);

        // 4. Capture while full accepted because the head leaves this cycle.
        push_n(8'h01, 4);
        ld_out   = 1'b1;
        bus      = 8'hA5;
        tx_ready = 1'b1;
        tick();
        ld_out = 1'b0;
        check_eq("fp_out",  32'(out),  32'h01);
        check_eq("fp_full", 32'(full), 32'd1);
        check_eq("fp_ovf",  32'(ovf),  32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            case (i)
                0:       check_eq("fp_drain", 32'(out), 32'h02);
                1:       check_eq("fp_drain", 32'(out), 32'h03);
                2:       check_eq("fp_drain", 32'(out), 32'h04);
                default: check_eq("fp_drain", 32'(out), 32'hA5);
            endcase
        end
        tx_ready = 1'b0;
        check_eq("fp_empty", 32'(empty), 32'd1);

        // 5. Streaming across pointer wrap with ready held high.
        tx_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ld_out = 1'b1;
            bus    = 8'h10 + 8'(k);
            tick();
            check_eq("wrap_full", 32'(full), 32'd0);
            if (k >= 1) begin
                check_eq("wrap_out", 32'(out), 32'(8'h10 + 8'(k - 1)));
            end else begin
                check_eq("wrap_first_out", 32'(out), 32'hA5);
            end
        end
        ld_out = 1'b0;
        tick();
        tx_ready = 1'b0;
        check_eq("wrap_last",  32'(out),   32'h19);
        check_eq("wrap_empty", 32'(empty), 32'd1);

        // 6. Overflow set wins over a simultaneous clear.
        push_n(8'h21, 4);
        ld_out = 1'b1;
        bus    = 8'hEE;
        tick();
        check_eq("ovf6_set", 32'(ovf), 32'd1);
        clr_ovf = 1'b1;
        tick();
        check_eq("ovf6_setwins", 32'(ovf), 32'd1);
        ld_out = 1'b0;
        tick();
        clr_ovf = 1'b0;
        check_eq("ovf6_clr",  32'(ovf),     32'd0);
        check_eq("ovf6_head", 32'(tx_data), 32'h21);
        check_eq("ovf6_full", 32'(full),    32'd1);

        // 7. Reset with three entries queued discards them.
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("r7_pop", 32'(out), 32'h21);
        res = 1'b1;
        tick();
        res = 1'b0;
        check_eq("r7_empty", 32'(empty),    32'd1);
        check_eq("r7_out",   32'(out),      32'h00);
        check_eq("r7_valid", 32'(tx_valid), 32'd0);
        check_eq("r7_full",  32'(full),     32'd0);
        ld_out = 1'b1;
        bus    = 8'h77;
        tick();
        ld_out = 1'b0;
        check_eq("r7_head", 32'(tx_data), 32'h77);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check_eq("r7_first", 32'(out),   32'h77);
        check_eq("r7_drain", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
